// File: rtl/tie_level_monitor.sv
// Tie-cell level monitor: synchronizes the tie-low/tie-high nets, filters persistent
// mismatches into sticky fault flags and counts raw mismatch episodes per net.
module tie_level_monitor #(
  parameter int FILT = 4,
  parameter int CW   = 8
) (
  input  logic          CLK,
  input  logic          RST,
  inout  wire           VDD,
  inout  wire           VSS,
  input  logic          TL,
  input  logic          TH,
  input  logic          EN,
  input  logic          CLR,
  output logic          FAULT_TL,
  output logic          FAULT_TH,
  output logic          FAULT,
  output logic [CW-1:0] CNT_TL,
  output logic [CW-1:0] CNT_TH
);

  localparam int            FW      = 4;
  localparam logic [FW-1:0] FILT_V  = FW'(FILT);
  localparam logic [CW-1:0] CNT_MAX = '1;

  // Supply pins are carried for netlist connectivity only.
  logic unused_pwr;
  assign unused_pwr = VDD ^ VSS;

  logic          tl_s1_q, tl_s2_q, th_s1_q, th_s2_q;
  logic          mprev_tl_q, mprev_th_q;
  logic [FW-1:0] f_tl_q, f_tl_d, f_th_q, f_th_d;
  logic          fault_tl_q, fault_tl_d, fault_th_q, fault_th_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] cnt_tl_q, cnt_tl_d, cnt_th_q, cnt_th_d;
  logic          m_tl, m_th;

  function automatic logic [FW-1:0] filt_next(input logic m, input logic [FW-1:0] f);
    if (!m)
      return '0;
    else if (f >= FILT_V)
      return FILT_V;
    else
      return f + FW'(1);
  endfunction

  function automatic logic filt_hit(input logic m, input logic [FW-1:0] f);
    return m && (f >= (FILT_V - FW'(1)));
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + CW'(1);
  endfunction

  assign m_tl = tl_s2_q;
  assign m_th = ~th_s2_q;

  always_comb begin
    f_tl_d     = f_tl_q;
    f_th_d     = f_th_q;
    fault_tl_d = fault_tl_q;
    fault_th_d = fault_th_q;
    cnt_tl_d   = cnt_tl_q;
    cnt_th_d   = cnt_th_q;
    fault_d    = fault_tl_q | fault_th_q;
    if (CLR) begin
      f_tl_d     = '0;
      f_th_d     = '0;
      fault_tl_d = 1'b0;
      fault_th_d = 1'b0;
      cnt_tl_d   = '0;
      cnt_th_d   = '0;
      fault_d    = 1'b0;
    end else if (EN) begin
      f_tl_d = filt_next(m_tl, f_tl_q);
      f_th_d = filt_next(m_th, f_th_q);
      if (filt_hit(m_tl, f_tl_q)) fault_tl_d = 1'b1;
      if (filt_hit(m_th, f_th_q)) fault_th_d = 1'b1;
      // Episodes are edges of the synchronized mismatch, independent of the filter.
      if (m_tl && !mprev_tl_q) cnt_tl_d = sat_inc(cnt_tl_q);
      if (m_th && !mprev_th_q) cnt_th_d = sat_inc(cnt_th_q);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tl_s1_q    <= 1'b0;
      tl_s2_q    <= 1'b0;
      th_s1_q    <= 1'b1;
      th_s2_q    <= 1'b1;
      mprev_tl_q <= 1'b0;
      mprev_th_q <= 1'b0;
      f_tl_q     <= '0;
      f_th_q     <= '0;
      fault_tl_q <= 1'b0;
      fault_th_q <= 1'b0;
      fault_q    <= 1'b0;
      cnt_tl_q   <= '0;
      cnt_th_q   <= '0;
    end else begin
      tl_s1_q    <= TL;
      tl_s2_q    <= tl_s1_q;
      th_s1_q    <= TH;
      th_s2_q    <= th_s1_q;
      // Tracks m even when disabled, so an episode spanning re-enable is not counted.
      mprev_tl_q <= m_tl;
      mprev_th_q <= m_th;
      f_tl_q     <= f_tl_d;
      f_th_q     <= f_th_d;
      fault_tl_q <= fault_tl_d;
      fault_th_q <= fault_th_d;
      fault_q    <= fault_d;
      cnt_tl_q   <= cnt_tl_d;
      cnt_th_q   <= cnt_th_d;
    end
  end

  assign FAULT_TL = fault_tl_q;
  assign FAULT_TH = fault_th_q;
  assign FAULT    = fault_q;
  assign CNT_TL   = cnt_tl_q;
  assign CNT_TH   = cnt_th_q;

endmodule
